// File: rtl/prep_mac_pipe.sv
// prep_mac_pipe: two-stage pipelined unsigned multiply-accumulate unit.
//   Stage 1 registers the full-width product A*B together with MAC and a valid bit.
//   Stage 2 loads or accumulates the (width-adjusted) product into Q.
// Optional feature macro: PREP_MAC_SAT_EN
//   defined   -> product truncation and accumulate carry saturate to all-ones, sticky OVF
//   undefined -> arithmetic wraps modulo 2^QW, OVF tied to 0
// Ports:
//   CLK      clock, rising edge
//   RST_N    asynchronous active-low reset
//   CLR      synchronous clear of accumulator, OVF and pipeline valids
//   IN_VLD   A/B/MAC valid this cycle
//   MAC      1: accumulate product into Q, 0: load product into Q
//   A, B     unsigned operands (AW / BW bits)
//   Q        accumulator (QW bits, registered)
//   OUT_VLD  one-cycle pulse when Q was updated by a sample
//   OVF      sticky saturation flag
module prep_mac_pipe #(
    parameter int unsigned AW = 4,
    parameter int unsigned BW = 4,
    parameter int unsigned QW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CLR,
    input  logic          IN_VLD,
    input  logic          MAC,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    output logic [QW-1:0] Q,
    output logic          OUT_VLD,
    output logic          OVF
);

    localparam int unsigned PW = AW + BW;

    logic [PW-1:0] p;
    logic          mac_r;
    logic          vld_r;
    logic [QW-1:0] p_low;

    // Stage 1: full-width product; P and mac_r hold while idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p     <= '0;
            mac_r <= 1'b0;
            vld_r <= 1'b0;
        end else if (CLR) begin
            vld_r <= 1'b0;
        end else if (IN_VLD) begin
            p     <= PW'(A) * PW'(B);
            mac_r <= MAC;
            vld_r <= 1'b1;
        end else begin
            vld_r <= 1'b0;
        end
    end

    // Product fitted to accumulator width: zero-extend or keep low bits
    generate
        if (QW >= PW) begin : g_ext
            assign p_low = QW'(p);
        end else begin : g_trunc
            assign p_low = p[QW-1:0];
        end
    endgenerate

`ifdef PREP_MAC_SAT_EN
    logic          p_big;
    logic [QW-1:0] p_sat;
    logic [QW:0]   sum;

    // Product does not fit in QW bits only when the product is wider than Q
    generate
        if (PW > QW) begin : g_big
            assign p_big = |p[PW-1:QW];
        end else begin : g_nobig
            assign p_big = 1'b0;
        end
    endgenerate

    // Saturated product and carry-extended sum
    always_comb begin
        p_sat = p_big ? {QW{1'b1}} : p_low;
        sum   = {1'b0, Q} + {1'b0, p_sat};
    end

    // Stage 2: load/accumulate with saturation and sticky overflow
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q       <= '0;
            OUT_VLD <= 1'b0;
            OVF     <= 1'b0;
        end else if (CLR) begin
            Q       <= '0;
            OUT_VLD <= 1'b0;
            OVF     <= 1'b0;
        end else if (vld_r) begin
            OUT_VLD <= 1'b1;
            if (mac_r) begin
                Q   <= sum[QW] ? {QW{1'b1}} : sum[QW-1:0];
                OVF <= OVF | p_big | sum[QW];
            end else begin
                // A load restarts the overflow history
                Q   <= p_sat;
                OVF <= p_big;
            end
        end else begin
            OUT_VLD <= 1'b0;
        end
    end
`else
    logic [QW-1:0] sum;

    // Wrapping sum; the carry out is simply dropped
    assign sum = Q + p_low;

    // Stage 2: load/accumulate modulo 2^QW
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q       <= '0;
            OUT_VLD <= 1'b0;
        end else if (CLR) begin
            Q       <= '0;
            OUT_VLD <= 1'b0;
        end else if (vld_r) begin
            OUT_VLD <= 1'b1;
            Q       <= mac_r ? sum : p_low;
        end else begin
            OUT_VLD <= 1'b0;
        end
    end

    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_prep_mac_pipe.sv
// Testbench for prep_mac_pipe: directed scenarios followed by random traffic,
// all checked against a transaction-level integer model of the MAC.
module tb_prep_mac_pipe;

    localparam int unsigned AW = 4;
    localparam int unsigned BW = 4;
    localparam int unsigned QW = 8;
    localparam int QMAX = (1 << QW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          CLR = 1'b0;
    logic          IN_VLD = 1'b0;
    logic          MAC = 1'b0;
    logic [AW-1:0] A = '0;
    logic [BW-1:0] B = '0;
    logic [QW-1:0] Q;
    logic          OUT_VLD;
    logic          OVF;

    int checks = 0;
    int errors = 0;

    // Reference state: accumulator, flag, output-valid, and the sample awaiting stage 2
    int m_q   = 0;
    int m_ovf = 0;
    int m_vld = 0;
    int pend_v = 0;
    int pend_mac = 0;
    int pend_a = 0;
    int pend_b = 0;

    prep_mac_pipe #(.AW(AW), .BW(BW), .QW(QW)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .IN_VLD(IN_VLD), .MAC(MAC),
        .A(A), .B(B), .Q(Q), .OUT_VLD(OUT_VLD), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample to the model using plain integer arithmetic
    task automatic model_apply(input int mac, input int a, input int b);
        int prod;
        int pp;
        int s;
        prod = a * b;
`ifdef PREP_MAC_SAT_EN
        pp = (prod > QMAX) ? QMAX : prod;
        if (mac != 0) begin
            s = m_q + pp;
            m_ovf = (m_ovf != 0 || prod > QMAX || s > QMAX) ? 1 : 0;
            m_q = (s > QMAX) ? QMAX : s;
        end else begin
            m_q = pp;
            m_ovf = (prod > QMAX) ? 1 : 0;
        end
`else
        pp = prod % (QMAX + 1);
        m_q = (mac != 0) ? (m_q + pp) % (QMAX + 1) : pp;
        m_ovf = 0;
`endif
    endtask

    task automatic model_reset();
        m_q = 0; m_ovf = 0; m_vld = 0; pend_v = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_q"},   32'(Q),       32'(m_q));
        chk({tag, "_vld"}, 32'(OUT_VLD), 32'(m_vld));
        chk({tag, "_ovf"}, 32'(OVF),     32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance one edge, update model, compare
    task automatic step(input string tag, input int clr, input int vld, input int mac,
                        input int a, input int b);
        CLR = clr[0]; IN_VLD = vld[0]; MAC = mac[0];
        A = AW'(a); B = BW'(b);
        @(posedge CLK);
        #1;
        if (clr != 0) begin
            m_q = 0; m_ovf = 0; m_vld = 0; pend_v = 0;
        end else begin
            m_vld = pend_v;
            if (pend_v != 0) model_apply(pend_mac, pend_a, pend_b);
            pend_v = vld; pend_mac = mac; pend_a = a; pend_b = b;
        end
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_model("reset");
        #3 RST_N = 1'b1;

        // 15*15 load appears two edges later
        step("t1_issue", 0, 1, 0, 15, 15);
        chk("t1_vld_early", 32'(OUT_VLD), 32'd0);
        idle("t1_out");
        chk("t1_q", 32'(Q), 32'd225);
        chk("t1_vld", 32'(OUT_VLD), 32'd1);
        idle("t1_drop");
        chk("t1_vld_pulse", 32'(OUT_VLD), 32'd0);

        // Accumulate 2*3 then 15*15 (overflow)
        step("t2_a", 0, 1, 1, 2, 3);
        step("t2_b", 0, 1, 1, 15, 15);
        chk("t2_q231", 32'(Q), 32'd231);
        idle("t2_c");
`ifdef PREP_MAC_SAT_EN
        chk("t2_qsat", 32'(Q), 32'd255);
        chk("t2_ovf", 32'(OVF), 32'd1);
`else
        chk("t2_qwrap", 32'(Q), 32'd200);
        chk("t2_ovf", 32'(OVF), 32'd0);
`endif

        // Back-to-back accumulates from zero
        step("t3_clr", 1, 0, 0, 0, 0);
        step("t3_s1", 0, 1, 1, 1, 1);
        step("t3_s2", 0, 1, 1, 2, 2);
        chk("t3_q1", 32'(Q), 32'd1);
        step("t3_s3", 0, 1, 1, 3, 3);
        chk("t3_q5", 32'(Q), 32'd5);
        step("t3_s4", 0, 1, 1, 4, 4);
        chk("t3_q14", 32'(Q), 32'd14);
        idle("t3_e1");
        chk("t3_q30", 32'(Q), 32'd30);
        chk("t3_vld", 32'(OUT_VLD), 32'd1);
        idle("t3_e2");

        // CLR with a sample in stage 2 and another presented
        step("t4_fill", 0, 1, 0, 7, 7);
        step("t4_clr", 1, 1, 0, 5, 5);
        chk("t4_q", 32'(Q), 32'd0);
        chk("t4_vld", 32'(OUT_VLD), 32'd0);
        idle("t4_after");
        chk("t4_q_after", 32'(Q), 32'd0);
        chk("t4_vld_after", 32'(OUT_VLD), 32'd0);

        // Asynchronous reset between edges
        step("t5_a", 0, 1, 0, 9, 9);
        step("t5_b", 0, 1, 1, 15, 15);
        RST_N = 1'b0;
        #2;
        model_reset();
        check_model("t5_async");
        #2 RST_N = 1'b1;
        step("t5_load", 0, 1, 0, 3, 4);
        idle("t5_out");
        chk("t5_q12", 32'(Q), 32'd12);

        // Gaps in the input stream
        step("t6_clr", 1, 0, 0, 0, 0);
        step("t6_s1", 0, 1, 1, 3, 3);
        step("t6_gap", 0, 0, 1, 0, 0);
        chk("t6_q9", 32'(Q), 32'd9);
        chk("t6_v1", 32'(OUT_VLD), 32'd1);
        step("t6_s2", 0, 1, 1, 2, 2);
        chk("t6_hold", 32'(Q), 32'd9);
        chk("t6_v0", 32'(OUT_VLD), 32'd0);
        idle("t6_out");
        chk("t6_q13", 32'(Q), 32'd13);
        chk("t6_v2", 32'(OUT_VLD), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, (1 << AW) - 1)),
                 int'($urandom_range(0, (1 << BW) - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
